psum_accum_buf: RTL and testbench
=================================

Name: psum_accum_buf

Overview:
- Parametrised on-chip partial-sum accumulator for the next-generation core datapath.
- Replaces the external pmem read-modify-write loop with an internal register array of `depth` entries, each `col` lanes of `psum_bw` bits.
- Sits between the corelet OFIFO output and the SFP/output path.
- Adds behaviour the current path lacks: pipelined read-modify-write with hazard forwarding, saturating signed accumulation, ReLU-on-readout, clear-on-read, and valid/ready handshakes on both ports.

Parameters:
- psum_bw, 16, width of one signed partial-sum lane
- col, 8, number of lanes per entry
- depth, 64, number of accumulator entries
- addr_bw, 6, address width; must satisfy 2**addr_bw >= depth

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  accumulate request valid
- in_ready  output  1  accumulate request accepted when high with in_valid
- in_addr  input  addr_bw  target entry
- in_first  input  1  1 = overwrite entry with in_data; 0 = accumulate
- in_data  input  col*psum_bw  lane i occupies bits [i*psum_bw +: psum_bw]; signed
- rd_valid  input  1  readout request valid
- rd_ready  output  1  readout request accepted when high with rd_valid
- rd_addr  input  addr_bw  entry to read
- rd_relu  input  1  apply per-lane max(0,x) on readout
- rd_clear  input  1  zero the entry as it is read
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  col*psum_bw  readout result
- sat_flag  output  1  sticky; set when any lane saturates

Behaviour:
- Reset (reset=0, async): all entries 0; s1_valid=0, s2_valid=0; out_valid=0; out_data=0; sat_flag=0. in_ready and rd_ready are combinational and follow the rules below immediately after reset.
- Accumulate pipeline, two stages:
  - Accept at edge T when in_valid & in_ready; s1 captures addr, first, data.
  - Cycle T+1 (s1): old = mem[s1_addr], registered into s2.
  - Cycle T+2 (s2): result = first ? data : sat_add(old, data); written to mem at the end of T+2.
  - Entry is visible to a read accepted at edge T+3.
- Forwarding:
  - If s1 and s2 are both valid with equal addr, s1 takes s2's result instead of mem.
  - Back-to-back accumulates to one address therefore sum correctly at one per cycle.
  - If s1 entered with first=1, the old value is ignored regardless of forwarding.
- Arithmetic:
  - Per-lane signed add in psum_bw+1 bits, then clamp to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - Any clamp sets sat_flag, which holds until reset.
  - Overwrite never saturates.
- in_ready = !(rd_valid & rd_ready); the accumulate pipeline itself never stalls.
- rd_ready = !s1_valid & !s2_valid & !in_valid & (!out_valid | out_ready).
  - Reads are accepted only when no write is pending or arriving.
  - When a read is accepted, in_ready is 0 in that cycle.
- Readout:
  - On acceptance, out_data <= rd_relu ? relu(mem[rd_addr]) : mem[rd_addr] per lane; out_valid <= 1. Latency is 1 cycle.
  - relu maps negative lanes to 0 and passes all others unchanged.
  - If rd_clear, mem[rd_addr] <= 0 at the same edge; the pre-clear value is the one output.
- Output register: out_data and out_valid hold while out_valid & !out_ready. out_valid drops when out_ready is high and no new read is accepted that edge.
- Out-of-range address (addr >= depth when depth < 2**addr_bw): writes are dropped; reads return 0.
- Reset mid-operation: in-flight pipeline and output are discarded; array contents are zeroed.

Decomposition:
- Shared package core_pkg:
  - PSUM_BW, COL, DEPTH, ADDR_BW defaults
  - lane-slice helper function
  - sat_add and relu lane functions, so the SFP can reuse them
- One sub-module, psum_lane_alu: single-lane sat_add plus saturation flag, instantiated col times in s2.
- Array, pipeline, and handshakes stay in the top.

Test Plan:
- Overwrite then read: in_first=1, addr 3, all lanes 5 → after drain, read addr 3 returns all lanes 5 with out_valid one cycle after acceptance.
- Back-to-back hazard: four consecutive accumulates to addr 7, lanes +1, first one in_first=1 → read returns 4 on every lane, sat_flag=0.
- Saturation: overwrite lane0=32760, accumulate +100 → lane0=32767, sat_flag=1. Overwrite lane1=-32760, accumulate -100 → lane1=-32768.
- ReLU + clear: entry lanes {-3,4,...}, read with rd_relu=1, rd_clear=1 → out {0,4,...}; second plain read → all 0.
- Backpressure/arbitration:
  - Hold out_ready=0 → out_data stable and rd_ready=0.
  - in_valid held high → rd_ready=0 until in_valid drops and the pipeline drains two cycles later.
- Async reset mid-stream: assert reset during an accumulate burst → outputs 0 immediately. After release, reading any entry returns 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core datapath definitions: default geometry plus lane-level arithmetic
// helpers that the partial-sum buffer and the SFP both use.
package core_pkg;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int DEPTH   = 64;
    localparam int ADDR_BW = 6;

    // Bit offset of a lane inside a packed multi-lane word.
    function automatic int lane_lsb(input int lane, input int bw);
        return lane * bw;
    endfunction

    function automatic logic [PSUM_BW-1:0] sat_add(input logic [PSUM_BW-1:0] a,
                                                   input logic [PSUM_BW-1:0] b);
        logic [PSUM_BW:0] s;
        s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        if (s[PSUM_BW] != s[PSUM_BW-1])
            return s[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
        return s[PSUM_BW-1:0];
    endfunction

    function automatic logic [PSUM_BW-1:0] relu(input logic [PSUM_BW-1:0] x);
        return x[PSUM_BW-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/psum_lane_alu.sv
// One signed partial-sum lane: add with one guard bit, clamp to the lane range,
// and report whether clamping happened.
module psum_lane_alu
    import core_pkg::*;
#(
    parameter int psum_bw = PSUM_BW
) (
    input  logic [psum_bw-1:0] old_val,
    input  logic [psum_bw-1:0] add_val,
    output logic [psum_bw-1:0] sum,
    output logic               sat
);

    localparam logic [psum_bw-1:0] MAX_VAL = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] MIN_VAL = {1'b1, {(psum_bw-1){1'b0}}};

    logic [psum_bw:0] wide;

    // Overflow shows up as disagreement between the guard bit and the lane sign bit.
    always_comb begin
        wide = {old_val[psum_bw-1], old_val} + {add_val[psum_bw-1], add_val};
        sat  = wide[psum_bw] ^ wide[psum_bw-1];
        if (!sat)
            sum = wide[psum_bw-1:0];
        else if (wide[psum_bw])
            sum = MIN_VAL;
        else
            sum = MAX_VAL;
    end

endmodule

// File: rtl/psum_accum_buf.sv
// On-chip partial-sum accumulator: two-stage read-modify-write with forwarding,
// saturating accumulation, and a one-cycle readout path with ReLU and clear-on-read.
module psum_accum_buf
    import core_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int depth   = DEPTH,
    parameter int addr_bw = ADDR_BW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [addr_bw-1:0]     in_addr,
    input  logic                   in_first,
    input  logic [col*psum_bw-1:0] in_data,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic [addr_bw-1:0]     rd_addr,
    input  logic                   rd_relu,
    input  logic                   rd_clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [col*psum_bw-1:0] out_data,
    output logic                   sat_flag
);

    localparam int                 DW        = col * psum_bw;
    localparam logic [addr_bw:0]   DEPTH_LIM = (addr_bw+1)'(depth);

    logic [DW-1:0]      mem [depth];

    logic               s1_valid;
    logic               s1_first;
    logic [addr_bw-1:0] s1_addr;
    logic [DW-1:0]      s1_data;
    logic [DW-1:0]      s1_old;

    logic               s2_valid;
    logic               s2_first;
    logic [addr_bw-1:0] s2_addr;
    logic [DW-1:0]      s2_data;
    logic [DW-1:0]      s2_old;
    logic [DW-1:0]      s2_result;

    logic [DW-1:0]      acc_sum;
    logic [col-1:0]     lane_sat;
    logic [DW-1:0]      rd_word;
    logic [DW-1:0]      rd_shaped;

    logic               in_fire;
    logic               rd_fire;
    logic               s1_in_range;
    logic               s2_in_range;
    logic               rd_in_range;

    function automatic logic in_range(input logic [addr_bw-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    // Reads only slip in when no write is in flight or arriving, so the array
    // never sees a read and a pipeline write to the same entry in one cycle.
    assign rd_ready    = !s1_valid && !s2_valid && !in_valid && (!out_valid || out_ready);
    assign in_ready    = !(rd_valid && rd_ready);
    assign in_fire     = in_valid && in_ready;
    assign rd_fire     = rd_valid && rd_ready;

    assign s1_in_range = in_range(s1_addr);
    assign s2_in_range = in_range(s2_addr);
    assign rd_in_range = in_range(rd_addr);

    assign s2_result   = s2_first ? s2_data : acc_sum;
    assign rd_word     = rd_in_range ? mem[rd_addr] : '0;

    // s2 writes the array only at the end of its cycle, so s1 must take the
    // in-flight result when both target the same entry.
    always_comb begin
        s1_old = '0;
        if (s2_valid && (s2_addr == s1_addr))
            s1_old = s2_result;
        else if (s1_in_range)
            s1_old = mem[s1_addr];
    end

    for (genvar i = 0; i < col; i++) begin : g_lane
        localparam int LSB = lane_lsb(i, psum_bw);

        psum_lane_alu #(
            .psum_bw (psum_bw)
        ) u_alu (
            .old_val (s2_old[LSB +: psum_bw]),
            .add_val (s2_data[LSB +: psum_bw]),
            .sum     (acc_sum[LSB +: psum_bw]),
            .sat     (lane_sat[i])
        );

        assign rd_shaped[LSB +: psum_bw] = (rd_relu && rd_word[LSB+psum_bw-1]) ? '0
                                                                                : rd_word[LSB +: psum_bw];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
            s2_old   <= '0;
        end else begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_addr  <= in_addr;
                s1_first <= in_first;
                s1_data  <= in_data;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_addr  <= s1_addr;
                s2_first <= s1_first;
                s2_data  <= s1_data;
                s2_old   <= s1_old;
            end
        end
    end

    // Pipeline write-back and clear-on-read never coincide because reads wait
    // for an empty pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++)
                mem[i] <= '0;
        end else begin
            if (s2_valid && s2_in_range)
                mem[s2_addr] <= s2_result;
            if (rd_fire && rd_clear && rd_in_range)
                mem[rd_addr] <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (rd_fire) begin
            out_valid <= 1'b1;
            out_data  <= rd_shaped;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Dropped out-of-range writes leave no trace, including on the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sat_flag <= 1'b0;
        else if (s2_valid && !s2_first && s2_in_range && (|lane_sat))
            sat_flag <= 1'b1;
    end

endmodule

// File: tb/tb_psum_accum_buf.sv
// Scoreboard bench for psum_accum_buf: directed scenarios plus randomized traffic
// checked against a plain-arithmetic model of the accumulator array.
module tb_psum_accum_buf;
    import core_pkg::*;

    localparam int PW = 16;
    localparam int NC = 8;
    localparam int ND = 64;
    localparam int AW = 6;
    localparam int DW = PW * NC;
    localparam int HI = (1 << (PW-1)) - 1;
    localparam int LO = -(1 << (PW-1));

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_addr   = '0;
    logic          in_first  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          rd_valid  = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_addr   = '0;
    logic          rd_relu   = 1'b0;
    logic          rd_clear  = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          sat_flag;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    int            model[ND][NC];
    bit            sat_model = 1'b0;
    bit            bp_en = 1'b0;

    psum_accum_buf #(
        .psum_bw (PW),
        .col     (NC),
        .depth   (ND),
        .addr_bw (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_first  (in_first),
        .in_data   (in_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rd_relu   (rd_relu),
        .rd_clear  (rd_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] fill(input int v);
        logic [DW-1:0] w;
        logic [PW-1:0] lane;
        lane = v[PW-1:0];
        for (int l = 0; l < NC; l++)
            w[l*PW +: PW] = lane;
        return w;
    endfunction

    function automatic logic [DW-1:0] model_word(input int a, input bit relu);
        logic [DW-1:0] w;
        logic [PW-1:0] lane;
        w = '0;
        for (int l = 0; l < NC; l++) begin
            int v = model[a][l];
            if (relu && v < 0)
                v = 0;
            lane = v[PW-1:0];
            w[l*PW +: PW] = lane;
        end
        return w;
    endfunction

    function automatic void model_acc(input int a, input bit first, input logic [DW-1:0] data);
        for (int l = 0; l < NC; l++) begin
            int d = int'($signed(data[l*PW +: PW]));
            if (first) begin
                model[a][l] = d;
            end else begin
                int s = model[a][l] + d;
                if (s > HI) begin
                    s = HI;
                    sat_model = 1'b1;
                end else if (s < LO) begin
                    s = LO;
                    sat_model = 1'b1;
                end
                model[a][l] = s;
            end
        end
    endfunction

    function automatic void model_clear_all();
        for (int a = 0; a < ND; a++)
            for (int l = 0; l < NC; l++)
                model[a][l] = 0;
        sat_model = 1'b0;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] w;
        logic [PW-1:0] lane;
        int            v;
        for (int l = 0; l < NC; l++) begin
            if ($urandom_range(0, 7) == 0)
                v = int'($urandom_range(20000, 32767));
            else
                v = int'($urandom_range(0, 1000));
            if ($urandom_range(0, 1) == 1)
                v = -v;
            lane = v[PW-1:0];
            w[l*PW +: PW] = lane;
        end
        return w;
    endfunction

    // Called at posedge+1; drives one request until accepted, then updates the model.
    task automatic applyStimulus(input bit is_rd, input logic [AW-1:0] addr, input bit first,
                                 input bit relu, input bit clear, input logic [DW-1:0] data);
        int waited = 0;
        bit ok = 1'b0;
        if (is_rd) begin
            in_valid = 1'b0;
            rd_valid = 1'b1;
            rd_addr  = addr;
            rd_relu  = relu;
            rd_clear = clear;
        end else begin
            rd_valid = 1'b0;
            in_valid = 1'b1;
            in_addr  = addr;
            in_first = first;
            in_data  = data;
        end
        forever begin
            @(negedge clk);
            ok = is_rd ? rd_ready : in_ready;
            if (ok)
                break;
            waited++;
            if (waited > 64) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL accept_timeout: got no handshake, expected one within 64 cycles");
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            if (is_rd) begin
                exp_q.push_back(model_word(int'(addr), relu));
                if (clear)
                    for (int l = 0; l < NC; l++)
                        model[addr][l] = 0;
            end else begin
                model_acc(int'(addr), first, data);
            end
        end
        @(posedge clk);
        #1;
        if (ok && is_rd)
            checkOutput("rd_latency", DW'(out_valid), DW'(1'b1));
        in_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic drainOutputs();
        int cyc = 0;
        while ((exp_q.size() != 0 || out_valid) && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 300) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("[TB] FAIL unexpected_output: got %h, expected no output", out_data);
                    end else begin
                        checkOutput("out_data", out_data, exp_q.pop_front());
                    end
                end else if (out_valid) begin
                    checkOutput("rd_ready_stall", DW'(rd_ready), DW'(1'b0));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en)
                out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        logic [PW-1:0] lane;
        int            v;

        model_clear_all();

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", DW'(out_valid), DW'(1'b0));
        checkOutput("rst_out_data", out_data, '0);
        checkOutput("rst_sat_flag", DW'(sat_flag), DW'(1'b0));
        checkOutput("rst_in_ready", DW'(in_ready), DW'(1'b1));
        checkOutput("rst_rd_ready", DW'(rd_ready), DW'(1'b1));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Overwrite then read
        applyStimulus(0, 6'd3, 1, 0, 0, fill(5));
        applyStimulus(1, 6'd3, 0, 0, 0, '0);
        drainOutputs();

        // Back-to-back accumulates to one address
        applyStimulus(0, 6'd7, 1, 0, 0, fill(1));
        applyStimulus(0, 6'd7, 0, 0, 0, fill(1));
        applyStimulus(0, 6'd7, 0, 0, 0, fill(1));
        applyStimulus(0, 6'd7, 0, 0, 0, fill(1));
        applyStimulus(1, 6'd7, 0, 0, 0, '0);
        drainOutputs();
        checkOutput("sat_flag_clean", DW'(sat_flag), DW'(sat_model));

        // Saturation high on lane 0, low on lane 1
        d = '0;
        v = 32760;  lane = v[PW-1:0]; d[0*PW +: PW] = lane;
        v = -32760; lane = v[PW-1:0]; d[1*PW +: PW] = lane;
        applyStimulus(0, 6'd10, 1, 0, 0, d);
        d = '0;
        v = 100;    lane = v[PW-1:0]; d[0*PW +: PW] = lane;
        v = -100;   lane = v[PW-1:0]; d[1*PW +: PW] = lane;
        applyStimulus(0, 6'd10, 0, 0, 0, d);
        applyStimulus(1, 6'd10, 0, 0, 0, '0);
        drainOutputs();
        checkOutput("sat_flag_set", DW'(sat_flag), DW'(sat_model));

        // ReLU with clear, then a plain read of the cleared entry
        d = '0;
        for (int l = 0; l < NC; l++) begin
            v = (l % 2 == 0) ? -(3 + l) : (3 + l);
            lane = v[PW-1:0];
            d[l*PW +: PW] = lane;
        end
        applyStimulus(0, 6'd12, 1, 0, 0, d);
        applyStimulus(1, 6'd12, 0, 1, 1, '0);
        applyStimulus(1, 6'd12, 0, 0, 0, '0);
        drainOutputs();

        // Output backpressure holds the data and blocks further reads
        out_ready = 1'b0;
        applyStimulus(1, 6'd3, 0, 0, 0, '0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("hold_data", out_data, exp_q[0]);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drainOutputs();

        // in_valid held high blocks reads until the pipeline drains
        in_valid = 1'b1;
        in_addr  = 6'd7;
        in_first = 1'b0;
        in_data  = fill(1);
        rd_valid = 1'b1;
        rd_addr  = 6'd7;
        rd_relu  = 1'b0;
        rd_clear = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rd_block_inv", DW'(rd_ready), DW'(1'b0));
            checkOutput("in_ready_inv", DW'(in_ready), DW'(1'b1));
            if (in_ready)
                model_acc(7, 0, fill(1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rd_block_drain", DW'(rd_ready), DW'(1'b0));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("rd_open_drain", DW'(rd_ready), DW'(1'b1));
        if (rd_ready)
            exp_q.push_back(model_word(7, 0));
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        checkOutput("rd_latency_drain", DW'(out_valid), DW'(1'b1));
        drainOutputs();

        // Randomized traffic with random output backpressure
        bp_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 7)
                applyStimulus(0, AW'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                              0, 0, rand_data());
            else
                applyStimulus(1, AW'($urandom_range(0, 15)), 0,
                              $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, '0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        bp_en = 1'b0;
        out_ready = 1'b1;
        drainOutputs();
        checkOutput("sat_flag_random", DW'(sat_flag), DW'(sat_model));

        // Async reset in the middle of an accumulate burst with an output pending
        out_ready = 1'b0;
        applyStimulus(1, 6'd7, 0, 0, 0, '0);
        in_valid = 1'b1;
        in_addr  = 6'd5;
        in_first = 1'b0;
        in_data  = fill(9);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_out_valid", DW'(out_valid), DW'(1'b0));
        checkOutput("midrst_out_data", out_data, '0);
        checkOutput("midrst_sat_flag", DW'(sat_flag), DW'(1'b0));
        exp_q.delete();
        model_clear_all();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(1, 6'd5, 0, 0, 0, '0);
        applyStimulus(1, 6'd7, 0, 0, 0, '0);
        applyStimulus(1, 6'd10, 0, 0, 0, '0);
        applyStimulus(1, AW'($urandom_range(0, ND-1)), 0, 0, 0, '0);
        drainOutputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
